legv8_multicycle_control: RTL and testbench

Multicycle control sequencer for the LEGv8 datapath. It latches each instruction word from the instruction ROM into an internal IR, decodes it, and steps through FETCH/EXEC/MEM states. In each state it drives the packed control word (constant, bus enables, mux selects, load and write enables, PC select, ALU function and register addresses) that the datapath unpacks. It also reads the datapath zero flag to resolve conditional branches.

---
 rtl/legv8_multicycle_control.sv | 212 +++++++++++++++++++++
 tb/tb_legv8_multicycle_control.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_control.sv
// Multicycle LEGv8 control sequencer.
// Latches each instruction into IR during FETCH, then decodes IR in EXEC
// (plus MEM for LDUR) and drives the packed control word for the datapath.
// Layout of control_word[DATA_WIDTH+29:0], MSB first:
// {constant, EN_PC, EN_Mem, EN_ALU, PCsel, Bsel, SL, WM, WR, PS[1:0],
//  FS[4:0], SB[4:0], SA[4:0], DA[4:0]}
module legv8_multicycle_control #(
  parameter int         DATA_WIDTH = 64,
  parameter logic [4:0] XZR        = 5'd31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             instruction,
  input  logic [4:0]              status,
  output logic [DATA_WIDTH+29:0]  control_word,
  output logic [2:0]              state,
  output logic                    halted
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    HALT  = 3'd7
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;

  state_t cur_state;
  state_t next_state;
  logic [31:0] ir;

  // Instruction fields and immediates, all taken from the latched IR
  logic [4:0] rd_f;
  logic [4:0] rn_f;
  logic [4:0] rm_f;
  logic [DATA_WIDTH-1:0] imm12_zext;
  logic [DATA_WIDTH-1:0] dt9_sext;
  logic [DATA_WIDTH-1:0] imm19_br;
  logic [DATA_WIDTH-1:0] imm26_br;

  assign rd_f       = ir[4:0];
  assign rn_f       = ir[9:5];
  assign rm_f       = ir[20:16];
  assign imm12_zext = {{(DATA_WIDTH-12){1'b0}}, ir[21:10]};
  assign dt9_sext   = {{(DATA_WIDTH-9){ir[20]}}, ir[20:12]};
  assign imm19_br   = {{(DATA_WIDTH-21){ir[23]}}, ir[23:5], 2'b00};
  assign imm26_br   = {{(DATA_WIDTH-28){ir[25]}}, ir[25:0], 2'b00};

  // Only the live zero flag steers branches; latched flags are ignored
  logic unused_status;
  assign unused_status = ^status[4:1];

  // Individual control fields before packing
  logic [DATA_WIDTH-1:0] constant;
  logic       en_pc;
  logic       en_mem;
  logic       en_alu;
  logic       pc_sel;
  logic       b_sel;
  logic       sl;
  logic       wm;
  logic       wr;
  logic [1:0] ps;
  logic [4:0] fs;
  logic [4:0] sb;
  logic [4:0] sa;
  logic [4:0] da;

  // State register and instruction latch, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_state <= FETCH;
      ir        <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == FETCH) begin
        ir <= instruction;
      end
    end
  end

  // Next-state and control field decode for the current state and IR
  always_comb begin
    next_state = cur_state;
    constant   = '0;
    en_pc      = 1'b0;
    en_mem     = 1'b0;
    en_alu     = 1'b0;
    pc_sel     = 1'b0;
    b_sel      = 1'b0;
    sl         = 1'b0;
    wm         = 1'b0;
    wr         = 1'b0;
    ps         = PS_HOLD;
    fs         = 5'b00000;
    sb         = 5'b00000;
    sa         = 5'b00000;
    da         = 5'b00000;

    case (cur_state)
      FETCH: begin
        next_state = EXEC;
      end

      EXEC: begin
        next_state = FETCH;
        if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
            ir[31:21] == OP_AND || ir[31:21] == OP_ORR) begin
          sa     = rn_f;
          sb     = rm_f;
          da     = rd_f;
          en_alu = 1'b1;
          wr     = 1'b1;
          ps     = PS_INC;
          case (ir[31:21])
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  fs = FS_SUB;
            OP_AND:  fs = FS_AND;
            default: fs = FS_ORR;
          endcase
        end else if (ir[31:21] == OP_LDUR) begin
          sa         = rn_f;
          b_sel      = 1'b1;
          constant   = dt9_sext;
          fs         = FS_ADD;
          da         = rd_f;
          next_state = MEM;
        end else if (ir[31:21] == OP_STUR) begin
          sa       = rn_f;
          sb       = rd_f;
          b_sel    = 1'b1;
          constant = dt9_sext;
          fs       = FS_ADD;
          wm       = 1'b1;
          ps       = PS_INC;
        end else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI) begin
          sa       = rn_f;
          sb       = rm_f;
          da       = rd_f;
          b_sel    = 1'b1;
          constant = imm12_zext;
          fs       = (ir[31:22] == OP_ADDI) ? FS_ADD : FS_SUB;
          en_alu   = 1'b1;
          wr       = 1'b1;
          ps       = PS_INC;
        end else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ) begin
          sa       = XZR;
          sb       = rd_f;
          fs       = FS_ORR;
          constant = imm19_br;
          if ((ir[31:24] == OP_CBZ) ? status[0] : !status[0]) begin
            ps = PS_BRANCH;
          end else begin
            ps = PS_INC;
          end
        end else if (ir[31:26] == OP_B) begin
          constant = imm26_br;
          ps       = PS_BRANCH;
        end else begin
          next_state = HALT;
        end
      end

      MEM: begin
        sa         = rn_f;
        b_sel      = 1'b1;
        constant   = dt9_sext;
        fs         = FS_ADD;
        en_mem     = 1'b1;
        wr         = 1'b1;
        da         = rd_f;
        ps         = PS_INC;
        next_state = FETCH;
      end

      HALT: begin
        next_state = HALT;
      end

      default: begin
        next_state = FETCH;
      end
    endcase
  end

  assign control_word = reset ? {constant, en_pc, en_mem, en_alu, pc_sel, b_sel, sl,
                                 wm, wr, ps, fs, sb, sa, da}
                              : '0;
  assign state        = cur_state;
  assign halted       = (cur_state == HALT);

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed testbench for legv8_multicycle_control.
module tb_legv8_multicycle_control;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [93:0] control_word;
  logic [2:0]  state;
  logic        halted;

  int tests_run;
  int tests_failed;

  legv8_multicycle_control #(.DATA_WIDTH(64), .XZR(5'd31)) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .state        (state),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pack an expected control word; PCsel and SL are always zero
  function automatic logic [93:0] mk_cw(input logic [63:0] k, input logic e_pc,
                                        input logic e_mem, input logic e_alu,
                                        input logic bsel, input logic wm, input logic wr,
                                        input logic [1:0] ps, input logic [4:0] fs,
                                        input logic [4:0] sb, input logic [4:0] sa,
                                        input logic [4:0] da);
    return {k, e_pc, e_mem, e_alu, 1'b0, bsel, 1'b0, wm, wr, ps, fs, sb, sa, da};
  endfunction

  // Present an instruction in FETCH and advance into EXEC; IR must hold it after
  task automatic issue(input logic [31:0] instr);
    instruction = instr;
    @(negedge clock);
    instruction = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    status      = 5'd0;
    instruction = 32'h8B02_0023;
    repeat (2) @(negedge clock);
    tests_run++;
    if (control_word !== 94'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cw: got %h expected 0", control_word);
    end
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state);
    end
    tests_run++;
    if (halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_halted: got %b expected 0", halted);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (control_word !== 94'd0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_cw: got %h expected 0", control_word);
    end
  endtask

  task automatic test_rtype(input string name, input logic [31:0] instr,
                            input logic [4:0] fs);
    logic [93:0] exp;
    exp = mk_cw(64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, fs, 5'd2, 5'd1, 5'd3);
    issue(instr);
    tests_run++;
    if (control_word !== exp || state !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL %s_exec: got cw=%h st=%0d expected cw=%h st=1",
               name, control_word, state, exp);
    end
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s_next: got state %0d expected 0", name, state);
    end
  endtask

  task automatic test_imm(input string name, input logic [31:0] instr,
                          input logic [4:0] fs);
    logic [93:0] exp;
    exp = mk_cw(64'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, fs, 5'd0, 5'd0, 5'd5);
    issue(instr);
    tests_run++;
    if (control_word !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s_exec: got %h expected %h", name, control_word, exp);
    end
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s_next: got state %0d expected 0", name, state);
    end
  endtask

  task automatic test_ldur(input string name, input logic [31:0] instr,
                           input logic [63:0] k);
    logic [93:0] exp_e;
    logic [93:0] exp_m;
    exp_e = mk_cw(k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'b01000, 5'd0, 5'd1, 5'd4);
    exp_m = mk_cw(k, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 5'b01000, 5'd0, 5'd1, 5'd4);
    issue(instr);
    tests_run++;
    if (control_word !== exp_e || state !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL %s_exec: got cw=%h st=%0d expected cw=%h st=1",
               name, control_word, state, exp_e);
    end
    @(negedge clock);
    tests_run++;
    if (control_word !== exp_m || state !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL %s_mem: got cw=%h st=%0d expected cw=%h st=2",
               name, control_word, state, exp_m);
    end
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s_next: got state %0d expected 0", name, state);
    end
  endtask

  task automatic test_stur();
    logic [93:0] exp;
    exp = mk_cw(64'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 5'b01000, 5'd4, 5'd1, 5'd0);
    issue(32'hF800_8024);
    tests_run++;
    if (control_word !== exp) begin
      tests_failed++;
      $display("[TB] FAIL stur_exec: got %h expected %h", control_word, exp);
    end
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL stur_next: got state %0d expected 0", state);
    end
  endtask

  task automatic test_branch(input string name, input logic [31:0] instr,
                             input logic zero, input logic [1:0] ps);
    logic [93:0] exp;
    exp = mk_cw(64'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps, 5'b00100, 5'd7, 5'd31, 5'd0);
    status = {4'b0000, zero};
    issue(instr);
    tests_run++;
    if (control_word !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, control_word, exp);
    end
    @(negedge clock);
    status = 5'd0;
  endtask

  task automatic test_b();
    logic [93:0] exp;
    exp = mk_cw(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                5'd0, 5'd0, 5'd0, 5'd0);
    issue(32'h17FF_FFFE);
    tests_run++;
    if (control_word !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b_exec: got %h expected %h", control_word, exp);
    end
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL b_next: got state %0d expected 0", state);
    end
  endtask

  task automatic test_halt(input string name, input logic [31:0] instr);
    int bad;
    issue(instr);
    tests_run++;
    if (control_word !== 94'd0 || state !== 3'd1 || halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_exec: got cw=%h st=%0d halted=%b expected 0,1,0",
               name, control_word, state, halted);
    end
    instruction = 32'h8B02_0023;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (control_word !== 94'd0 || state !== 3'd7 || halted !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_hold: got %0d bad cycles (last st=%0d halted=%b) expected 0",
               name, bad, state, halted);
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_reset: got st=%0d halted=%b expected 0,0", name, state, halted);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_in_mem();
    logic [93:0] exp;
    issue(32'hF840_8024);
    @(negedge clock);
    tests_run++;
    if (state !== 3'd2 || control_word[22] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rmem_reach: got st=%0d wr=%b expected 2,1", state, control_word[22]);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (control_word !== 94'd0) begin
      tests_failed++;
      $display("[TB] FAIL rmem_cw: got %h expected 0", control_word);
    end
    @(negedge clock);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL rmem_state: got %0d expected 0", state);
    end
    reset = 1'b1;
    exp = mk_cw(64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 5'b01000, 5'd2, 5'd1, 5'd3);
    issue(32'h8B02_0023);
    tests_run++;
    if (control_word !== exp) begin
      tests_failed++;
      $display("[TB] FAIL rmem_after: got %h expected %h", control_word, exp);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [3];
    int          exp_cyc [3];
    int          cyc;
    int          ps_count;
    int          multi_en;
    instrs  = '{32'h8B02_0023, 32'hF840_8024, 32'h17FF_FFFE};
    exp_cyc = '{2, 3, 2};
    for (int n = 0; n < 3; n++) begin
      instruction = instrs[n];
      cyc      = 0;
      ps_count = (control_word[21:20] != 2'b00) ? 1 : 0;
      multi_en = 0;
      do begin
        @(negedge clock);
        instruction = 32'hFFFF_FFFF;
        cyc++;
        if (state != 3'd0) begin
          if (control_word[21:20] != 2'b00) ps_count++;
          if ($countones(control_word[29:27]) > 1) multi_en++;
        end
      end while (state != 3'd0 && cyc < 10);
      tests_run++;
      if (cyc != exp_cyc[n]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_cycles[%0d]: got %0d expected %0d", n, cyc, exp_cyc[n]);
      end
      tests_run++;
      if (ps_count != 1 || multi_en != 0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_invariants[%0d]: got ps_count=%0d multi_en=%0d expected 1,0",
                 n, ps_count, multi_en);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    status       = 5'd0;
    instruction  = 32'd0;
    test_reset();
    test_rtype("add", 32'h8B02_0023, 5'b01000);
    test_rtype("sub", 32'hCB02_0023, 5'b01001);
    test_rtype("and", 32'h8A02_0023, 5'b00000);
    test_rtype("orr", 32'hAA02_0023, 5'b00100);
    test_imm("addi", 32'h9100_2805, 5'b01000);
    test_imm("subi", 32'hD100_2805, 5'b01001);
    test_ldur("ldur_pos", 32'hF840_8024, 64'd8);
    test_ldur("ldur_neg", 32'hF85F_8024, 64'hFFFF_FFFF_FFFF_FFF8);
    test_stur();
    test_branch("cbz_taken", 32'hB400_0067, 1'b1, 2'b10);
    test_branch("cbz_not_taken", 32'hB400_0067, 1'b0, 2'b01);
    test_branch("cbnz_taken", 32'hB500_0067, 1'b0, 2'b10);
    test_branch("cbnz_not_taken", 32'hB500_0067, 1'b1, 2'b01);
    test_b();
    test_halt("halt_zero", 32'h0000_0000);
    test_halt("halt_unknown", 32'hFFFF_FFFF);
    test_reset_in_mem();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
